// File: rtl/block_accum_pkg.sv
// Shared definitions for the block accumulator: FSM encoding, config/status field layout
// and the reserved-address limit that protects the config and status cells.
package block_accum_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRead,
        StAcc,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned CfgStartBit   = 0;
    localparam int unsigned CfgSrcLsb     = 2;
    localparam int unsigned CfgSrcWidth   = 10;
    localparam int unsigned CfgDstLsb     = 12;
    localparam int unsigned CfgDstWidth   = 10;
    localparam int unsigned CfgCountLsb   = 22;
    localparam int unsigned CfgCountWidth = 8;

    localparam int unsigned StatBusyBit    = 0;
    localparam int unsigned StatDoneBit    = 1;
    localparam int unsigned StatErrorBit   = 2;
    localparam int unsigned StatCountLsb   = 8;
    localparam int unsigned StatCountWidth = 8;

    // Cells 0 and 1 hold config and status; block transfers must stay above them.
    localparam int unsigned ReservedLimit = 2;

endpackage

// File: rtl/block_accum_if.sv
// Memory-side bus of the block accumulator: config/status cells plus the block port.
interface block_accum_if #(
    parameter int unsigned CELL_WIDTH = 32,
    parameter int unsigned LOG_SIZE   = 10,
    parameter int unsigned WIDTH      = 128
);
    logic [CELL_WIDTH-1:0] in_config;
    logic [WIDTH-1:0]      in_rdata;
    logic [LOG_SIZE-1:0]   out_address;
    logic                  out_read_en;
    logic                  out_write_en;
    logic [WIDTH-1:0]      out_wdata;
    logic [CELL_WIDTH-1:0] out_status;
    logic                  out_write_status_en;

    modport master (
        input  in_config, in_rdata,
        output out_address, out_read_en, out_write_en, out_wdata, out_status,
        output out_write_status_en
    );

    modport slave (
        output in_config, in_rdata,
        input  out_address, out_read_en, out_write_en, out_wdata, out_status,
        input  out_write_status_en
    );
endinterface

// File: rtl/block_lane_adder.sv
// Combinational per-lane adder: each CELL_WIDTH lane wraps independently, no carry across lanes.
module block_lane_adder #(
    parameter int unsigned BLOCKS     = 4,
    parameter int unsigned CELL_WIDTH = 32
) (
    input  logic [BLOCKS*CELL_WIDTH-1:0] a,
    input  logic [BLOCKS*CELL_WIDTH-1:0] b,
    output logic [BLOCKS*CELL_WIDTH-1:0] sum
);
    for (genvar k = 0; k < BLOCKS; k++) begin : g_lane
        assign sum[k*CELL_WIDTH +: CELL_WIDTH] =
            a[k*CELL_WIDTH +: CELL_WIDTH] + b[k*CELL_WIDTH +: CELL_WIDTH];
    end
endmodule

// File: rtl/block_accum.sv
// Sums count consecutive memory blocks lane-wise and writes the result block to dst,
// reporting progress through the status cell.
module block_accum
    import block_accum_pkg::*;
#(
    parameter int unsigned BLOCKS     = 4,
    parameter int unsigned CELL_WIDTH = 32,
    parameter int unsigned LOG_SIZE   = 10,
    parameter int unsigned WIDTH      = BLOCKS * CELL_WIDTH
) (
    input logic           in_clk,
    input logic           in_reset,
    block_accum_if.master bus
);
    localparam int unsigned MemSize = 1 << LOG_SIZE;

    state_e                   state_q, state_d;
    logic                     start_q;
    logic [CfgSrcWidth-1:0]   src_q;
    logic [CfgDstWidth-1:0]   dst_q;
    logic [CfgCountWidth-1:0] count_q;
    logic [CfgCountWidth-1:0] idx_q;
    logic [WIDTH-1:0]         acc_q;
    logic [WIDTH-1:0]         acc_sum;
    logic [31:0]              src_end;
    logic [31:0]              dst_end;
    logic                     start_req;
    logic                     cfg_error;
    logic                     last_block;
    logic                     unused_cfg;

    assign start_req = bus.in_config[CfgStartBit] & ~start_q;
    assign src_end   = 32'(src_q) + BLOCKS * 32'(count_q);
    assign dst_end   = 32'(dst_q) + BLOCKS;
    assign cfg_error = (count_q == '0) || (32'(src_q) < ReservedLimit) ||
                       (32'(dst_q) < ReservedLimit) || (src_end > MemSize) || (dst_end > MemSize);
    // idx_q is incremented in the same ACC cycle, so compare against the post-increment value.
    assign last_block = (9'(idx_q) + 9'd1) >= 9'(count_q);
    assign unused_cfg = ^{bus.in_config[CELL_WIDTH-1:CfgCountLsb+CfgCountWidth], bus.in_config[1]};

    block_lane_adder #(
        .BLOCKS     (BLOCKS),
        .CELL_WIDTH (CELL_WIDTH)
    ) u_lane_adder (
        .a   (acc_q),
        .b   (bus.in_rdata),
        .sum (acc_sum)
    );

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_req) state_d = StCheck;
            StCheck: state_d = cfg_error ? StDone : StRead;
            StRead:  state_d = StAcc;
            StAcc:   state_d = last_block ? StWrite : StRead;
            StWrite: state_d = StDone;
            StDone:  if (!start_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.out_address         = '0;
        bus.out_read_en         = 1'b0;
        bus.out_write_en        = 1'b0;
        bus.out_wdata           = '0;
        bus.out_status          = '0;
        bus.out_write_status_en = 1'b0;
        unique case (state_q)
            StCheck: begin
                bus.out_write_status_en = 1'b1;
                if (cfg_error) bus.out_status[StatErrorBit] = 1'b1;
                else           bus.out_status[StatBusyBit]  = 1'b1;
            end
            StRead: begin
                bus.out_read_en = 1'b1;
                bus.out_address = LOG_SIZE'(32'(src_q) + BLOCKS * 32'(idx_q));
            end
            StWrite: begin
                bus.out_write_en        = 1'b1;
                bus.out_address         = LOG_SIZE'(dst_q);
                bus.out_wdata           = acc_q;
                bus.out_write_status_en = 1'b1;
                bus.out_status[StatDoneBit] = 1'b1;
                bus.out_status[StatCountLsb +: StatCountWidth] = count_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            start_q <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            start_q <= bus.in_config[CfgStartBit];
            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        src_q   <= bus.in_config[CfgSrcLsb +: CfgSrcWidth];
                        dst_q   <= bus.in_config[CfgDstLsb +: CfgDstWidth];
                        count_q <= bus.in_config[CfgCountLsb +: CfgCountWidth];
                    end
                end
                StCheck: begin
                    idx_q <= '0;
                    if (!cfg_error) acc_q <= '0;
                end
                StAcc: begin
                    acc_q <= acc_sum;
                    idx_q <= idx_q + CfgCountWidth'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_accum.sv
// Scoreboard bench for block_accum: a memory model serves blocks, expected status/write
// events are queued at start and popped as the DUT produces them.
module tb_block_accum;
    localparam int unsigned Blocks   = 4;
    localparam int unsigned CellW    = 32;
    localparam int unsigned LogSize  = 10;
    localparam int unsigned Width    = Blocks * CellW;
    localparam int          MemCells = 1024;

    typedef struct {
        logic [9:0]   addr;
        logic [127:0] data;
        int           lat;
    } wr_t;

    logic in_clk = 1'b0;
    logic in_reset;

    block_accum_if #(.CELL_WIDTH(CellW), .LOG_SIZE(LogSize), .WIDTH(Width)) bus ();

    block_accum #(
        .BLOCKS     (Blocks),
        .CELL_WIDTH (CellW),
        .LOG_SIZE   (LogSize),
        .WIDTH      (Width)
    ) dut (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .bus      (bus)
    );

    always #5 in_clk = ~in_clk;

    logic [31:0] mem [MemCells];
    wr_t         exp_wr_q[$];
    logic [31:0] exp_st_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int chk_cyc = 0;
    int n_status = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cfg(input int src, input int dst, input int cnt,
                                        input logic st);
        logic [31:0] c;
        c        = '0;
        c[0]     = st;
        c[11:2]  = 10'(src);
        c[21:12] = 10'(dst);
        c[29:22] = 8'(cnt);
        c[31:30] = 2'b11;  // ignored bits
        c[1]     = 1'b1;
        return c;
    endfunction

    // Memory model and event monitor: sample outputs at negedge, update memory at posedge.
    task automatic bus_model();
        logic rd, wr;
        logic [9:0] addr;
        logic [127:0] wd;
        logic [31:0] es;
        wr_t ew;
        forever begin
            @(negedge in_clk);
            rd = bus.out_read_en;
            wr = bus.out_write_en;
            addr = bus.out_address;
            wd = bus.out_wdata;
            if (in_reset) begin
                if (rd || wr) check("rd_wr_excl", 128'(rd & wr), 128'(0));
                if (bus.out_write_status_en) begin
                    n_status++;
                    if (exp_st_q.size() == 0) begin
                        check("unexp_status", 128'(bus.out_write_status_en), 128'(0));
                    end else begin
                        es = exp_st_q.pop_front();
                        check("status", 128'(bus.out_status), 128'(es));
                    end
                    if (bus.out_status[0]) chk_cyc = cyc;
                end
                if (wr) begin
                    if (exp_wr_q.size() == 0) begin
                        check("unexp_write", 128'(wr), 128'(0));
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("wr_addr", 128'(addr), 128'(ew.addr));
                        check("wr_data", wd, ew.data);
                        check("latency", 128'(cyc - chk_cyc + 1), 128'(ew.lat));
                    end
                end
            end
            @(posedge in_clk);
            cyc++;
            for (int k = 0; k < Blocks; k++) begin
                if (rd) bus.in_rdata[k*32 +: 32] <= mem[(int'(addr) + k) % MemCells];
                if (wr) mem[(int'(addr) + k) % MemCells] <= wd[k*32 +: 32];
            end
        end
    endtask

    task automatic expect_op(input int src, input int dst, input int cnt, output int tgt);
        logic err;
        logic [127:0] sum;
        wr_t ew;
        err = (cnt == 0) || (src < 2) || (dst < 2) || (src + Blocks * cnt > MemCells) ||
              (dst + Blocks > MemCells);
        if (err) begin
            exp_st_q.push_back(32'h4);
            tgt = n_status + 1;
        end else begin
            sum = '0;
            for (int b = 0; b < cnt; b++)
                for (int k = 0; k < Blocks; k++)
                    sum[k*32 +: 32] = sum[k*32 +: 32] + mem[(src + Blocks * b + k) % MemCells];
            exp_st_q.push_back(32'h1);
            exp_st_q.push_back(32'h2 | (32'(cnt) << 8));
            ew.addr = 10'(dst);
            ew.data = sum;
            ew.lat  = 2 * cnt + 2;
            exp_wr_q.push_back(ew);
            tgt = n_status + 2;
        end
    endtask

    // Waits for the op's status writes, then holds start high to show no retrigger.
    task automatic finish_op(input int tgt);
        int n;
        n = 0;
        while (n_status < tgt && n < 2000) begin
            @(posedge in_clk);
            n++;
        end
        if (n_status < tgt) check("timeout", 128'(n_status), 128'(tgt));
        repeat (8) @(posedge in_clk);
        #1;
        check("sb_status_empty", 128'(exp_st_q.size()), 128'(0));
        check("sb_write_empty", 128'(exp_wr_q.size()), 128'(0));
        bus.in_config[0] = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
    endtask

    task automatic run_op(input int src, input int dst, input int cnt);
        int tgt;
        bus.in_config = cfg(src, dst, cnt, 1'b0);
        @(posedge in_clk);
        #1;
        expect_op(src, dst, cnt, tgt);
        bus.in_config[0] = 1'b1;
        finish_op(tgt);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_addr"}, 128'(bus.out_address), 128'(0));
        check({tag, "_rd"}, 128'(bus.out_read_en), 128'(0));
        check({tag, "_wr"}, 128'(bus.out_write_en), 128'(0));
        check({tag, "_wdata"}, bus.out_wdata, 128'(0));
        check({tag, "_status"}, 128'(bus.out_status), 128'(0));
        check({tag, "_st_en"}, 128'(bus.out_write_status_en), 128'(0));
    endtask

    initial begin
        int tgt;
        int reads;
        int n;
        in_reset = 1'b0;
        for (int i = 0; i < MemCells; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            mem[8 + i]  = 32'(i + 1);
            mem[12 + i] = 32'(10 * (i + 1));
        end
        mem[300] = 32'hFFFF_FFFF; mem[301] = 32'd5; mem[302] = 32'h8000_0000; mem[303] = 32'd0;
        mem[304] = 32'd2;         mem[305] = 32'd7; mem[306] = 32'h8000_0000; mem[307] = 32'd1;
        fork
            bus_model();
        join_none

        // Start already high while in reset: one operation right after release.
        bus.in_config = cfg(8, 100, 2, 1'b1);
        repeat (2) @(posedge in_clk);
        #1;
        check_quiet("reset");
        expect_op(8, 100, 2, tgt);
        in_reset = 1'b1;
        finish_op(tgt);
        check("mem100", 128'(mem[100]), 128'(11));
        check("mem101", 128'(mem[101]), 128'(22));
        check("mem102", 128'(mem[102]), 128'(33));
        check("mem103", 128'(mem[103]), 128'(44));

        run_op(8, 100, 0);     // count 0
        run_op(8, 1, 1);       // dst reserved
        run_op(1, 100, 1);     // src reserved
        run_op(1000, 100, 7);  // source overruns memory
        run_op(996, 100, 7);   // source ends exactly at the top
        run_op(8, 1021, 1);    // destination overruns memory
        run_op(8, 1020, 1);    // destination ends exactly at the top

        run_op(300, 400, 2);   // lane wrap
        check("wrap_lane0", 128'(mem[400]), 128'(1));
        check("wrap_lane1", 128'(mem[401]), 128'(12));
        check("wrap_lane2", 128'(mem[402]), 128'(0));
        check("wrap_lane3", 128'(mem[403]), 128'(1));

        run_op(16, 16, 2);     // destination overlaps sources
        run_op(8, 100, 2);     // second toggle after a held start
        run_op(2, 1020, 255);  // maximum count

        // Reset while accumulating: no write may reach the destination.
        for (int i = 0; i < 4; i++) mem[200 + i] = 32'hDEAD_0000 + 32'(i);
        bus.in_config = cfg(8, 200, 5, 1'b0);
        @(posedge in_clk);
        #1;
        exp_st_q.push_back(32'h1);
        bus.in_config[0] = 1'b1;
        reads = 0;
        n = 0;
        while (reads < 3 && n < 200) begin
            @(negedge in_clk);
            if (bus.out_read_en) reads++;
            n++;
        end
        if (reads < 3) check("rd_timeout", 128'(reads), 128'(3));
        @(posedge in_clk);
        #1;
        in_reset = 1'b0;
        bus.in_config[0] = 1'b0;
        #1;
        check_quiet("rst_mid");
        repeat (3) @(posedge in_clk);
        #1;
        check_quiet("rst_hold");
        in_reset = 1'b1;
        repeat (10) @(posedge in_clk);
        #1;
        check("rst_no_write", 128'(mem[200]), 128'(32'hDEAD_0000));
        check("rst_no_write3", 128'(mem[203]), 128'(32'hDEAD_0003));
        check("rst_sb_status", 128'(exp_st_q.size()), 128'(0));
        run_op(8, 100, 2);     // back to normal from IDLE

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
